inst_sequencer: RTL

- Instruction fetch/issue stage that sits directly upstream of the PE-array `control` decoder. It drives that decoder's `inst_v` and `opcode` inputs.
- Holds a small instruction memory, loaded over a host write port.
- On `start`, steps a program counter through the first `prog_len` words. Each word is issued as its opcode for (repeat+1) valid cycles, honouring a downstream `stall`.
- Signals `busy`/`done` back to the host.

---
 rtl/inst_sequencer_pkg.sv | 23 ++
 rtl/inst_sequencer_mem.sv | 34 +++
 rtl/inst_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared constants for the instruction sequencer: FSM encodings, opcodes and field positions.
package inst_sequencer_pkg;

  localparam int unsigned INST_WIDTH_DEF = 32;
  localparam int unsigned REP_WIDTH_DEF  = 8;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 29;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_MULADD = 3'b101;
  localparam logic [2:0] OP_MULSUB = 3'b110;
  localparam logic [2:0] OP_MAX    = 3'b111;

endpackage

// File: rtl/inst_sequencer_mem.sv
// Simple dual-port instruction RAM: synchronous write, registered read with enable.
module inst_mem #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction fetch/issue sequencer feeding the PE-array control decoder.
// Optional macro SEQ_LOOP_EN adds loop_cnt to repeat the whole program.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int unsigned INST_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned INST_WIDTH = INST_WIDTH_DEF,
  parameter int unsigned REP_WIDTH  = REP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [INST_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]            loop_cnt,
`endif
  input  logic                  stall,
  output logic                  inst_v,
  output logic [2:0]            opcode,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = LEN_W'(INST_DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [REP_WIDTH-1:0]  cnt_q, cnt_d;
  logic [INST_WIDTH-1:0] inst_reg;
  logic [REP_WIDTH-1:0]  rep;
  logic                  pc_last;
  logic                  rep_last;
  logic                  issue_last;
  logic                  loop_again;
  logic                  unused_rsvd;

  assign rep         = inst_reg[REP_WIDTH-1:0];
  assign unused_rsvd = ^inst_reg[OPC_LSB-1:REP_WIDTH];

  assign busy = (state_q == ST_FETCH) || (state_q == ST_ISSUE);

  // The memory read register doubles as inst_reg; it loads only in FETCH.
  inst_mem #(
    .DEPTH      (INST_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (INST_WIDTH)
  ) u_inst_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (state_q == ST_FETCH),
    .raddr (pc_q),
    .rdata (inst_reg)
  );

  assign pc_last    = ({1'b0, pc_q} == (len_q - LEN_W'(1)));
  // Counts issues upward and compares against rep, so rep need not be known at the fetch edge.
  assign rep_last   = (cnt_q == rep);
  assign issue_last = (state_q == ST_ISSUE) && !stall && rep_last && pc_last;

`ifdef SEQ_LOOP_EN
  logic [7:0] loops_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loops_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      loops_q <= loop_cnt;
    end else if (issue_last && (loops_q != '0)) begin
      loops_q <= loops_q - 8'd1;
    end
  end

  assign loop_again = (loops_q != '0);
`else
  assign loop_again = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
            pc_d    = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        cnt_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!stall) begin
          if (!rep_last) begin
            cnt_d = cnt_q + REP_WIDTH'(1);
          end else if (pc_last) begin
            if (loop_again) begin
              pc_d    = '0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_v = (state_q == ST_ISSUE) && !stall;
  assign opcode = busy ? inst_reg[OPC_MSB:OPC_LSB] : OP_LOAD;
  assign done   = (state_q == ST_DONE);

endmodule
